instr_encoder: RTL and testbench

//  Inverse of the main decoder: assembles RV32I machine words from field-level requests
//  (kind, rd, rs1, rs2, funct3, imm) for the subset the core executes (lw, sw, R-type,
//  beq, blt, I-type ALU, jal, lui). Sits between the bench/boot loader and instruction memory.

---
 rtl/instr_encoder_pkg.sv | 38 +++
 rtl/instr_encoder_if.sv | 33 +++
 rtl/instr_encoder_fields.sv | 55 +++++
 rtl/instr_encoder.sv | 80 ++++++++
 tb/tb_instr_encoder.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared encodings for the RV32I instruction encoder: request kinds, opcodes,
// the canonical NOP and the controller states.
package instr_pkg;

  typedef enum logic [3:0] {
    KIND_LW  = 4'd0,
    KIND_SW  = 4'd1,
    KIND_R   = 4'd2,
    KIND_BEQ = 4'd3,
    KIND_BLT = 4'd4,
    KIND_I   = 4'd5,
    KIND_JAL = 4'd6,
    KIND_LUI = 4'd7,
    KIND_END = 4'd8
  } kind_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  // Signed range test on a full 32-bit immediate.
  function automatic logic fits(input logic [31:0] v, input int lo, input int hi);
    return ($signed(v) >= lo) && ($signed(v) <= hi);
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request/response bus of the instruction encoder; the encoder uses the slave
// view, the producer/consumer side uses the master view.
interface instr_encoder_if #(
  parameter int ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_kind;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic              in_f7b5;
  logic [31:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;

  modport master (
    output in_valid, in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_f7b5, in_imm,
    input  in_ready,
    input  out_valid, out_instr, out_addr,
    output out_ready
  );

  modport slave (
    input  in_valid, in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_f7b5, in_imm,
    output in_ready,
    output out_valid, out_instr, out_addr,
    input  out_ready
  );
endinterface

// File: rtl/instr_encoder_fields.sv
// Combinational field packer: request kind + fields -> RV32I word, with an
// illegal flag for out-of-range immediates or unknown kinds (word becomes NOP).
module instr_fields
  import instr_pkg::*;
(
  input  logic [3:0]  kind,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic        f7b5,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal
);
  logic [31:0] raw;
  logic        bad;

  always_comb begin
    raw = NOP;
    bad = 1'b0;
    case (kind)
      KIND_LW: begin
        raw = {imm[11:0], rs1, 3'b010, rd, OP_LOAD};
        bad = !fits(imm, -2048, 2047);
      end
      KIND_SW: begin
        raw = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_STORE};
        bad = !fits(imm, -2048, 2047);
      end
      KIND_R: raw = {1'b0, f7b5, 5'b00000, rs2, rs1, funct3, rd, OP_REG};
      KIND_I: begin
        raw = {imm[11:0], rs1, funct3, rd, OP_IMM};
        bad = !fits(imm, -2048, 2047);
      end
      KIND_BEQ, KIND_BLT: begin
        raw = {imm[12], imm[10:5], rs2, rs1, (kind == KIND_BEQ) ? 3'b000 : 3'b100,
               imm[4:1], imm[11], OP_BRANCH};
        bad = !fits(imm, -4096, 4094) || imm[0];
      end
      KIND_JAL: begin
        raw = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
        bad = !fits(imm, -(1 << 20), (1 << 20) - 2) || imm[0];
      end
      KIND_LUI: begin
        raw = {imm[31:12], rd, OP_LUI};
        bad = (imm[11:0] != 12'h000);
      end
      KIND_END: bad = 1'b0;
      default:  bad = 1'b1;
    endcase
    illegal = bad;
    word    = bad ? NOP : raw;
  end
endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: accepts field-level requests, emits {address, word}
// pairs through a single output register with an auto-incrementing PC.
module instr_encoder
  import instr_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  instr_encoder_if.slave    bus,
  output logic              done,
  output logic              err,
  output logic [7:0]        err_cnt
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc;
  logic              accept;
  logic              is_end;
  logic [31:0]       word;
  logic              illegal;

  instr_fields u_fields (
    .kind    (bus.in_kind),
    .rd      (bus.in_rd),
    .rs1     (bus.in_rs1),
    .rs2     (bus.in_rs2),
    .funct3  (bus.in_funct3),
    .f7b5    (bus.in_f7b5),
    .imm     (bus.in_imm),
    .word    (word),
    .illegal (illegal)
  );

  assign is_end = (bus.in_kind == KIND_END);
  assign done   = (state_q == ST_DONE) && !bus.out_valid;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // start outranks a simultaneous request, so acceptance is masked by it.
  always_comb begin
    state_d      = state_q;
    bus.in_ready = (state_q == ST_RUN) && (!bus.out_valid || bus.out_ready);
    accept       = bus.in_ready && bus.in_valid && !start;
    if (start)                 state_d = ST_RUN;
    else if (accept && is_end) state_d = ST_DONE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.out_valid <= 1'b0;
      bus.out_instr <= '0;
      bus.out_addr  <= '0;
      pc            <= '0;
      err           <= 1'b0;
      err_cnt       <= '0;
    end else begin
      if (bus.out_valid && bus.out_ready) bus.out_valid <= 1'b0;
      if (accept && !is_end) begin
        bus.out_valid <= 1'b1;
        bus.out_instr <= word;
        bus.out_addr  <= pc;
        pc            <= pc + ADDR_W'(4);
      end
      // A restart reloads pc last so it overrides the increment; output still drains.
      if (start) begin
        pc      <= start_addr;
        err     <= 1'b0;
        err_cnt <= '0;
      end else if (accept && illegal) begin
        err <= 1'b1;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: vector table plus handshake,
// restart, saturation, wrap and reset sequences, scoreboard on the output side.
module tb_instr_encoder;
  import instr_pkg::*;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic              done, err;
  logic [7:0]        err_cnt;

  instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  instr_encoder #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .bus        (bus),
    .done       (done),
    .err        (err),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  kind;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic        f7b5;
    logic [31:0] imm;
    logic [31:0] word;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       word;
  } exp_t;

  exp_t              sbq[$];
  exp_t              mon_e;
  int                checks = 0;
  int                errors = 0;
  logic [ADDR_W-1:0] mpc = '0;
  int                merr = 0;
  vec_t              tbl[26];
  vec_t              va, vb, vend, vbad;

  function automatic vec_t mk(input logic [3:0] kind, input int rd, input int rs1,
                              input int rs2, input int f3, input int f7,
                              input logic [31:0] imm, input logic [31:0] word,
                              input int ill);
    vec_t v;
    v.kind = kind; v.rd = 5'(rd); v.rs1 = 5'(rs1); v.rs2 = 5'(rs2);
    v.f3 = 3'(f3); v.f7b5 = 1'(f7); v.imm = imm; v.word = word; v.ill = 1'(ill);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.in_kind = v.kind; bus.in_rd = v.rd; bus.in_rs1 = v.rs1; bus.in_rs2 = v.rs2;
    bus.in_funct3 = v.f3; bus.in_f7b5 = v.f7b5; bus.in_imm = v.imm;
  endtask

  task automatic send(input vec_t v);
    bit   ok;
    exp_t e;
    ok = 1'b0;
    drive(v);
    bus.in_valid = 1'b1;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        if (v.kind != KIND_END) begin
          e.addr = mpc; e.word = v.word;
          sbq.push_back(e);
          mpc = mpc + ADDR_W'(4);
        end
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=in_ready_low expected=accept_within_50");
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] a);
    start = 1'b1; start_addr = a;
    @(posedge clk); #1;
    start = 1'b0;
    mpc = a; merr = 0;
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 20; c++) begin
      if (sbq.size() == 0 && !bus.out_valid) break;
      @(posedge clk); #1;
    end
    chk("drain_pending", 32'(sbq.size()), 32'd0);
  endtask

  // Output monitor: scoreboard pop on transfer, stability check while stalled.
  logic              prev_stall = 1'b0;
  logic [31:0]       prev_instr = '0;
  logic [ADDR_W-1:0] prev_addr = '0;

  always @(negedge clk) begin
    if (reset) begin
      if (prev_stall) begin
        chk("hold_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("hold_instr", bus.out_instr, prev_instr);
        chk("hold_addr", bus.out_addr, prev_addr);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output actual=0x%08h@0x%08h expected=none",
                   bus.out_instr, bus.out_addr);
        end else begin
          mon_e = sbq.pop_front();
          chk("out_instr", bus.out_instr, mon_e.word);
          chk("out_addr", bus.out_addr, mon_e.addr);
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_instr = bus.out_instr;
      prev_addr  = bus.out_addr;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = mk(KIND_I,   1, 0, 0, 0, 0, 5,            32'h00500093, 0);
    tbl[1]  = mk(KIND_LW,  2, 1, 0, 0, 0, 8,            32'h0080A103, 0);
    tbl[2]  = mk(KIND_SW,  0, 1, 2, 0, 0, 4,            32'h0020A223, 0);
    tbl[3]  = mk(KIND_R,   3, 1, 2, 0, 0, 0,            32'h002081B3, 0);
    tbl[4]  = mk(KIND_R,   3, 1, 2, 0, 1, 0,            32'h402081B3, 0);
    tbl[5]  = mk(KIND_BEQ, 0, 1, 2, 0, 0, -4,           32'hFE208EE3, 0);
    tbl[6]  = mk(KIND_JAL, 1, 0, 0, 0, 0, 8,            32'h008000EF, 0);
    tbl[7]  = mk(KIND_LUI, 5, 0, 0, 0, 0, 32'h12345000, 32'h123452B7, 0);
    tbl[8]  = mk(KIND_I,   1, 0, 0, 0, 0, 2048,         NOP, 1);
    tbl[9]  = mk(KIND_BEQ, 0, 1, 2, 0, 0, 3,            NOP, 1);
    tbl[10] = mk(KIND_I,   1, 0, 0, 0, 0, 2047,         32'h7FF00093, 0);
    tbl[11] = mk(KIND_I,   1, 0, 0, 0, 0, -2048,        32'h80000093, 0);
    tbl[12] = mk(KIND_I,   1, 0, 0, 0, 0, -2049,        NOP, 1);
    tbl[13] = mk(KIND_BLT, 0, 3, 4, 0, 0, 4094,         32'h7E41CFE3, 0);
    tbl[14] = mk(KIND_BEQ, 0, 0, 0, 0, 0, -4096,        32'h80000063, 0);
    tbl[15] = mk(KIND_BEQ, 0, 0, 0, 0, 0, 4096,         NOP, 1);
    tbl[16] = mk(KIND_JAL, 0, 0, 0, 0, 0, -1048576,     32'h8000006F, 0);
    tbl[17] = mk(KIND_JAL, 0, 0, 0, 0, 0, 1048574,      32'h7FFFF06F, 0);
    tbl[18] = mk(KIND_JAL, 0, 0, 0, 0, 0, 1048576,      NOP, 1);
    tbl[19] = mk(KIND_JAL, 0, 0, 0, 0, 0, 5,            NOP, 1);
    tbl[20] = mk(KIND_LUI, 1, 0, 0, 0, 0, 32'h00001001, NOP, 1);
    tbl[21] = mk(4'hF,     1, 2, 3, 0, 0, 0,            NOP, 1);
    tbl[22] = mk(KIND_SW,  0, 2, 5, 0, 0, -1,           32'hFE512FA3, 0);
    tbl[23] = mk(KIND_I,   6, 7, 0, 4, 0, -1,           32'hFFF3C313, 0);
    tbl[24] = mk(KIND_R,  10, 11, 12, 5, 1, 0,          32'h40C5D533, 0);
    tbl[25] = mk(KIND_SW,  0, 1, 2, 0, 0, 2048,         NOP, 1);
    va   = mk(KIND_I,   7, 0, 0, 0, 0, 1,  32'h00100393, 0);
    vb   = mk(KIND_R,   3, 1, 2, 0, 0, 0,  32'h002081B3, 0);
    vend = mk(KIND_END, 0, 0, 0, 0, 0, 0,  NOP, 0);
    vbad = mk(4'hF,     0, 0, 0, 0, 0, 0,  NOP, 1);

    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drive(va);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_err_cnt", {24'b0, err_cnt}, 32'd0);
    chk("rst_out_instr", bus.out_instr, 32'd0);
    chk("rst_out_addr", bus.out_addr, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", {31'b0, bus.in_ready}, 32'd0);

    // Vector table
    do_start(32'h100);
    chk("run_in_ready", {31'b0, bus.in_ready}, 32'd1);
    for (int i = 0; i < 26; i++) begin
      send(tbl[i]);
      if (tbl[i].ill) merr++;
      chk("err_cnt", {24'b0, err_cnt}, 32'(merr));
      chk("err", {31'b0, err}, (merr != 0) ? 32'd1 : 32'd0);
    end
    wait_drain();

    // Back-pressure with a second request waiting
    bus.out_ready = 1'b0;
    send(va);
    drive(vb);
    bus.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", {31'b0, bus.in_ready}, 32'd0);
      chk("stall_out_valid", {31'b0, bus.out_valid}, 32'd1);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    send(vb);
    wait_drain();

    // END handling and restart
    chk("run_done", {31'b0, done}, 32'd0);
    send(va);
    send(vb);
    send(vend);
    chk("end_done", {31'b0, done}, 32'd1);
    chk("end_in_ready", {31'b0, bus.in_ready}, 32'd0);
    drive(va);
    bus.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("done_in_ready", {31'b0, bus.in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    wait_drain();
    do_start(32'h200);
    chk("restart_done", {31'b0, done}, 32'd0);
    chk("restart_err", {31'b0, err}, 32'd0);
    chk("restart_err_cnt", {24'b0, err_cnt}, 32'd0);

    // start beats a simultaneous request
    drive(vb);
    bus.in_valid = 1'b1;
    start = 1'b1; start_addr = 32'h300;
    @(posedge clk); #1;
    start = 1'b0;
    mpc = 32'h300;
    send(vb);
    wait_drain();

    // PC wrap
    do_start(32'hFFFF_FFF8);
    repeat (3) send(va);
    wait_drain();

    // Error counter saturation
    do_start(32'h0);
    for (int i = 0; i < 260; i++) send(vbad);
    chk("sat_err_cnt", {24'b0, err_cnt}, 32'd255);
    chk("sat_err", {31'b0, err}, 32'd1);
    wait_drain();

    // Reset while output is occupied
    bus.out_ready = 1'b0;
    send(va);
    @(negedge clk);
    chk("pre_reset_valid", {31'b0, bus.out_valid}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
    chk("mid_rst_err_cnt", {24'b0, err_cnt}, 32'd0);
    chk("mid_rst_err", {31'b0, err}, 32'd0);
    chk("mid_rst_out_addr", bus.out_addr, 32'd0);
    sbq.delete();
    reset = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", {31'b0, bus.in_ready}, 32'd0);
    do_start(32'h40);
    send(va);
    wait_drain();

    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
